timer_sched: RTL and testbench

- Multi-channel interval-timer scheduler built around a shared mod-P prescaler that produces a one-cycle base tick.
- Each of CH channels counts down a programmable number of base ticks in one-shot or periodic mode.
- Channels are started and stopped through a command interface.
- Expiries go to one shared event output, one channel at a time, in round-robin order with valid/ready handshake; this is the timebase for slow LED, debounce and UART-timeout logic.

---
 rtl/timer_sched.sv | 132 +++++++++++++
 tb/tb_timer_sched.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_sched.sv
// timer_sched: shared-prescaler multi-channel interval timer with round-robin expiry events
module timer_sched #(
  parameter int CW = 2,
  parameter int W  = 16,
  parameter int P  = 50000,
  parameter int PW = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [CW-1:0]     cmd_ch,
  input  logic [W-1:0]      cmd_load,
  output logic              cmd_err,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CW-1:0]     evt_ch,
  output logic              evt_overrun,
  output logic [2**CW-1:0]  active,
  output logic              base_tick
);
  localparam int CH = 2**CW;
  typedef enum logic [1:0] {IDLE, RUN_OS, RUN_PER} state_t;
  state_t        r_state [CH];
  state_t        w_state_nx [CH];
  logic [W-1:0]  r_cnt [CH];
  logic [W-1:0]  w_cnt_nx [CH];
  logic [W-1:0]  r_reload [CH];
  logic [W-1:0]  w_reload_nx [CH];
  logic [CH-1:0] r_pend, w_pend_nx, r_ovr, w_ovr_nx, w_gnt_oh;
  logic [PW-1:0] r_presc;
  logic [CW-1:0] r_rr, w_gnt_ch, r_evt_ch;
  logic          r_cmd_ready, r_cmd_err, r_evt_valid, r_evt_ovr;
  logic          w_accept, w_start, w_stop, w_tick, w_free, w_gnt;
  assign w_accept    = cmd_valid & r_cmd_ready;
  assign w_start     = cmd_op[0] ^ cmd_op[1];
  assign w_stop      = &cmd_op;
  assign w_tick      = r_presc == PW'(P - 1);
  assign w_free      = ~r_evt_valid | evt_ready;
  assign base_tick   = w_tick;
  assign cmd_ready   = r_cmd_ready;
  assign cmd_err     = r_cmd_err;
  assign evt_valid   = r_evt_valid;
  assign evt_ch      = r_evt_ch;
  assign evt_overrun = r_evt_ovr;
  // free-running mod-P prescaler; base tick is decoded from its terminal value
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_presc <= '0;
    else r_presc <= w_tick ? '0 : r_presc + PW'(1);
  // round-robin search for the nearest pending channel after the last grant
  always_comb begin
    w_gnt    = 1'b0;
    w_gnt_ch = '0;
    for (int k = CH; k >= 1; k--)
      if (r_pend[r_rr + CW'(k)]) begin
        w_gnt    = 1'b1;
        w_gnt_ch = r_rr + CW'(k);
      end
    for (int i = 0; i < CH; i++) w_gnt_oh[i] = w_free & w_gnt & (w_gnt_ch == CW'(i));
  end
  // per-channel next state: a command on the channel beats a coincident base tick
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      w_state_nx[i]  = r_state[i];
      w_cnt_nx[i]    = r_cnt[i];
      w_reload_nx[i] = r_reload[i];
      w_pend_nx[i]   = r_pend[i] & ~w_gnt_oh[i];
      w_ovr_nx[i]    = r_ovr[i] & ~w_gnt_oh[i];
      if (w_accept && cmd_ch == CW'(i) && w_stop && r_state[i] != IDLE) begin
        w_state_nx[i] = IDLE;
        w_cnt_nx[i]   = '0;
        w_pend_nx[i]  = 1'b0;
        w_ovr_nx[i]   = 1'b0;
      end else if (w_accept && cmd_ch == CW'(i) && w_start && cmd_load != '0) begin
        w_state_nx[i]  = cmd_op[0] ? RUN_OS : RUN_PER;
        w_cnt_nx[i]    = cmd_load;
        w_reload_nx[i] = cmd_load;
      end else if (w_tick && r_state[i] != IDLE) begin
        if (r_cnt[i] == W'(1)) begin
          w_pend_nx[i]  = 1'b1;
          w_ovr_nx[i]   = w_ovr_nx[i] | (r_pend[i] & ~w_gnt_oh[i]);
          w_cnt_nx[i]   = r_state[i] == RUN_PER ? r_reload[i] : '0;
          w_state_nx[i] = r_state[i] == RUN_PER ? RUN_PER : IDLE;
        end else w_cnt_nx[i] = r_cnt[i] - W'(1);
      end
    end
  end
  // channel state registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < CH; i++) begin
        r_state[i]  <= IDLE;
        r_cnt[i]    <= '0;
        r_reload[i] <= '0;
      end
      r_pend <= '0;
      r_ovr  <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        r_state[i]  <= w_state_nx[i];
        r_cnt[i]    <= w_cnt_nx[i];
        r_reload[i] <= w_reload_nx[i];
      end
      r_pend <= w_pend_nx;
      r_ovr  <= w_ovr_nx;
    end
  // command handshake, error pulse and the registered event slot
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_cmd_ready <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_evt_valid <= 1'b0;
      r_evt_ch    <= '0;
      r_evt_ovr   <= 1'b0;
      r_rr        <= '1;
    end else begin
      r_cmd_ready <= 1'b1;
      r_cmd_err   <= w_accept & w_start & (cmd_load == '0);
      if (w_free) begin
        r_evt_valid <= w_gnt;
        if (w_gnt) begin
          r_evt_ch  <= w_gnt_ch;
          r_evt_ovr <= r_ovr[w_gnt_ch];
          r_rr      <= w_gnt_ch;
        end
      end
    end
  // running flags
  always_comb
    for (int i = 0; i < CH; i++) active[i] = r_state[i] != IDLE;
endmodule

// File: tb/tb_timer_sched.sv
// tb_timer_sched: directed checks of timer_sched with CW=2, W=8, P=4
module tb_timer_sched;
  localparam int CW = 2;
  localparam int W  = 8;
  localparam int P  = 4;
  localparam int PW = 2;
  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [CW-1:0] cmd_ch = '0;
  logic [W-1:0]  cmd_load = '0;
  logic          cmd_err;
  logic          evt_valid;
  logic          evt_ready = 1'b0;
  logic [CW-1:0] evt_ch;
  logic          evt_overrun;
  logic [3:0]    active;
  logic          base_tick;
  int            n_chk = 0;
  int            n_fail = 0;
  timer_sched #(.CW(CW), .W(W), .P(P), .PW(PW)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_load(cmd_load), .cmd_err(cmd_err),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch),
    .evt_overrun(evt_overrun), .active(active), .base_tick(base_tick)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [1:0] op, input logic [CW-1:0] ch, input logic [W-1:0] load);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_ch    = ch;
    cmd_load  = load;
    step(1);
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(cmd_ready), 0);
    chk({tag, "_err"}, 32'(cmd_err), 0);
    chk({tag, "_evalid"}, 32'(evt_valid), 0);
    chk({tag, "_ech"}, 32'(evt_ch), 0);
    chk({tag, "_eovr"}, 32'(evt_overrun), 0);
    chk({tag, "_active"}, 32'(active), 0);
    chk({tag, "_tick"}, 32'(base_tick), 0);
  endtask
  initial begin
    #2 reset_n = 1'b0;
    #1 chk_all_zero("por");
    @(negedge clk);
    reset_n = 1'b1;
    // one-shot ch1 L=3
    evt_ready = 1'b1;
    chk("t1_ready_n0", 32'(cmd_ready), 0);
    chk("t1_tick_n0", 32'(base_tick), 0);
    step(1);
    chk("t1_ready_n1", 32'(cmd_ready), 1);
    send(2'b01, 2'd1, 8'd3);
    chk("t1_active_n2", 32'(active), 32'h2);
    step(1);
    chk("t1_first_tick", 32'(base_tick), 1);
    step(8);
    chk("t1_tick3", 32'(base_tick), 1);
    chk("t1_active_n11", 32'(active), 32'h2);
    step(1);
    chk("t1_active_n12", 32'(active), 0);
    chk("t1_valid_n12", 32'(evt_valid), 0);
    step(1);
    chk("t1_valid_n13", 32'(evt_valid), 1);
    chk("t1_ch_n13", 32'(evt_ch), 1);
    chk("t1_ovr_n13", 32'(evt_overrun), 0);
    step(1);
    chk("t1_valid_n14", 32'(evt_valid), 0);
    step(10);
    chk("t1_valid_n24", 32'(evt_valid), 0);
    // periodic ch0 L=2 with stalled consumer
    do_reset();
    evt_ready = 1'b0;
    step(1);
    send(2'b10, 2'd0, 8'd2);
    step(7);
    chk("t2_valid_n9", 32'(evt_valid), 1);
    chk("t2_ch_n9", 32'(evt_ch), 0);
    chk("t2_ovr_n9", 32'(evt_overrun), 0);
    step(11);
    chk("t2_valid_n20", 32'(evt_valid), 1);
    chk("t2_ovr_n20", 32'(evt_overrun), 0);
    step(11);
    chk("t2_valid_n31", 32'(evt_valid), 1);
    chk("t2_ch_n31", 32'(evt_ch), 0);
    chk("t2_ovr_n31", 32'(evt_overrun), 0);
    step(1);
    evt_ready = 1'b1;
    step(1);
    chk("t2_valid_n33", 32'(evt_valid), 1);
    chk("t2_ch_n33", 32'(evt_ch), 0);
    chk("t2_ovr_n33", 32'(evt_overrun), 1);
    step(1);
    chk("t2_valid_n34", 32'(evt_valid), 0);
    step(7);
    chk("t2_valid_n41", 32'(evt_valid), 1);
    chk("t2_ovr_n41", 32'(evt_overrun), 0);
    step(1);
    chk("t2_valid_n42", 32'(evt_valid), 0);
    step(7);
    chk("t2_valid_n49", 32'(evt_valid), 1);
    // four simultaneous one-shot expiries, round-robin order
    do_reset();
    evt_ready = 1'b1;
    step(3);
    send(2'b01, 2'd3, 8'd1);
    send(2'b01, 2'd2, 8'd1);
    send(2'b01, 2'd1, 8'd1);
    send(2'b01, 2'd0, 8'd1);
    chk("t3_active_n7", 32'(active), 32'hf);
    chk("t3_tick_n7", 32'(base_tick), 1);
    step(1);
    chk("t3_active_n8", 32'(active), 0);
    chk("t3_valid_n8", 32'(evt_valid), 0);
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk($sformatf("t3_valid_%0d", k), 32'(evt_valid), 1);
      chk($sformatf("t3_ch_%0d", k), 32'(evt_ch), 32'(k));
    end
    step(1);
    chk("t3_valid_n13", 32'(evt_valid), 0);
    // zero-load rejection and stop mid-count
    do_reset();
    evt_ready = 1'b1;
    step(1);
    send(2'b10, 2'd2, 8'd0);
    chk("t4_err_n2", 32'(cmd_err), 1);
    chk("t4_active_n2", 32'(active), 0);
    step(1);
    chk("t4_err_n3", 32'(cmd_err), 0);
    send(2'b01, 2'd2, 8'd5);
    chk("t4_active_n4", 32'(active), 32'h4);
    step(4);
    send(2'b11, 2'd2, 8'd0);
    chk("t4_active_n9", 32'(active), 0);
    chk("t4_err_n9", 32'(cmd_err), 0);
    for (int k = 0; k < 6; k++) begin
      step(5);
      chk($sformatf("t4_noevt_%0d", k), 32'(evt_valid), 0);
    end
    // START coincident with base tick ignores that tick
    do_reset();
    evt_ready = 1'b1;
    step(3);
    chk("t5_tick_n3", 32'(base_tick), 1);
    send(2'b01, 2'd0, 8'd1);
    chk("t5_active_n4", 32'(active), 32'h1);
    step(1);
    chk("t5_valid_n5", 32'(evt_valid), 0);
    chk("t5_active_n5", 32'(active), 32'h1);
    step(2);
    chk("t5_active_n7", 32'(active), 32'h1);
    step(1);
    chk("t5_active_n8", 32'(active), 0);
    step(1);
    chk("t5_valid_n9", 32'(evt_valid), 1);
    chk("t5_ch_n9", 32'(evt_ch), 0);
    step(1);
    chk("t5_valid_n10", 32'(evt_valid), 0);
    // asynchronous reset while an event is presented
    do_reset();
    evt_ready = 1'b0;
    step(1);
    send(2'b10, 2'd1, 8'd1);
    send(2'b10, 2'd3, 8'd2);
    step(2);
    chk("t6_valid_n5", 32'(evt_valid), 1);
    chk("t6_ch_n5", 32'(evt_ch), 1);
    chk("t6_active_n5", 32'(active), 32'ha);
    reset_n = 1'b0;
    #1 chk_all_zero("t6_rst");
    @(negedge clk);
    reset_n = 1'b1;
    evt_ready = 1'b1;
    step(2);
    chk("t6_tick_n2", 32'(base_tick), 0);
    step(1);
    chk("t6_tick_n3", 32'(base_tick), 1);
    for (int k = 0; k < 4; k++) begin
      step(2);
      chk($sformatf("t6_stale_%0d", k), 32'(evt_valid), 0);
      chk($sformatf("t6_idle_%0d", k), 32'(active), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
